// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone N-slave decoder.
package wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        ERR    = 2'b10
    } wb_dec_state_e;

    localparam logic [1:0] WB_ERR_NONE     = 2'b00;
    localparam logic [1:0] WB_ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] WB_ERR_SLAVE    = 2'b10;
    localparam logic [1:0] WB_ERR_TIMEOUT  = 2'b11;

    // Width of a slave index; a single slave still needs one bit.
    function automatic int wb_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Combinational priority address decoder: lowest matching slave index wins.
module wb_addr_match
    import wb_pkg::*;
#(
    parameter int NUM_SLAVES = 8,
    parameter int AW         = WB_AW,
    parameter int IW         = wb_idx_width(NUM_SLAVES)
) (
    input  logic [AW-1:0]                  i_adr,
    input  logic [NUM_SLAVES-1:0][AW-1:0]  i_base,
    input  logic [NUM_SLAVES-1:0][AW-1:0]  i_mask,
    output logic                           o_hit,
    output logic [IW-1:0]                  o_idx
);

    // Scan from the highest index down so the lowest matching index is left in place
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((i_adr & i_mask[k]) == i_base[k]) begin
                o_hit = 1'b1;
                o_idx = IW'(k);
            end else begin
                o_hit = o_hit;
                o_idx = o_idx;
            end
        end
    end

endmodule

// File: rtl/wb_nslave_decoder.sv
// Single-master Wishbone classic router for NUM_SLAVES slaves with registered
// slave select, per-transfer timeout, unmapped-address error and a sticky
// first-error capture register.
module wb_nslave_decoder
    import wb_pkg::*;
#(
    parameter int                             NUM_SLAVES = 8,
    parameter int                             AW         = WB_AW,
    parameter int                             DW         = WB_DW,
    parameter logic [NUM_SLAVES-1:0][AW-1:0]  SLV_BASE   = '0,
    parameter logic [NUM_SLAVES-1:0][AW-1:0]  SLV_MASK   = '0,
    parameter int                             TIMEOUT    = 255
) (
    input  logic                           clk,
    input  logic                           reset_n,
    // master side
    input  logic [AW-1:0]                  m_adr_i,
    input  logic [DW-1:0]                  m_dat_i,
    input  logic [DW/8-1:0]                m_sel_i,
    input  logic                           m_we_i,
    input  logic                           m_cyc_i,
    input  logic                           m_stb_i,
    output logic [DW-1:0]                  m_dat_o,
    output logic                           m_ack_o,
    output logic                           m_err_o,
    // slave side
    output logic [AW-1:0]                  s_adr_o,
    output logic [DW-1:0]                  s_dat_o,
    output logic [DW/8-1:0]                s_sel_o,
    output logic                           s_we_o,
    output logic [NUM_SLAVES-1:0]          s_cyc_o,
    output logic [NUM_SLAVES-1:0]          s_stb_o,
    input  logic [NUM_SLAVES-1:0][DW-1:0]  s_dat_i,
    input  logic [NUM_SLAVES-1:0]          s_ack_i,
    input  logic [NUM_SLAVES-1:0]          s_err_i,
    // error capture
    output logic                           err_valid_o,
    output logic [AW-1:0]                  err_adr_o,
    output logic [1:0]                     err_cause_o,
    input  logic                           err_clr_i
);

    localparam int IW = wb_idx_width(NUM_SLAVES);
    localparam int CW = $clog2(TIMEOUT + 1);

    wb_dec_state_e           r_state;
    logic [IW-1:0]           r_idx;
    logic [CW-1:0]           r_cnt;
    logic                    r_err_valid;
    logic [AW-1:0]           r_err_adr;
    logic [1:0]              r_err_cause;

    logic                    w_hit;
    logic [IW-1:0]           w_idx;
    logic                    w_active;
    logic                    w_req;
    logic                    w_sel_ack;
    logic                    w_sel_err;
    logic [DW-1:0]           w_sel_dat;
    logic                    w_resp_ack;
    logic                    w_resp_err;
    logic                    w_cnt_last;
    logic                    w_timeout;
    logic                    w_unmapped;
    logic                    w_new_err;
    logic [1:0]              w_new_cause;
    logic [NUM_SLAVES-1:0]   w_sel_vec;

    wb_addr_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .AW         (AW),
        .IW         (IW)
    ) u_match (
        .i_adr  (m_adr_i),
        .i_base (SLV_BASE),
        .i_mask (SLV_MASK),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    // Address/data/select/we are broadcast; only cyc/stb are steered
    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;
    assign s_we_o  = m_we_i;

    assign w_active   = (r_state == ACTIVE);
    assign w_req      = m_cyc_i & m_stb_i;
    assign w_sel_ack  = s_ack_i[r_idx];
    assign w_sel_err  = s_err_i[r_idx];
    assign w_sel_dat  = s_dat_i[r_idx];
    assign w_cnt_last = (r_cnt == CW'(TIMEOUT - 1));

    // A dropped m_cyc_i aborts silently, so responses are masked by it; err beats ack
    assign w_resp_err = w_active & m_cyc_i & w_sel_err;
    assign w_resp_ack = w_active & m_cyc_i & w_sel_ack & ~w_sel_err;
    assign w_timeout  = w_active & m_cyc_i & ~w_sel_ack & ~w_sel_err & w_cnt_last;
    assign w_unmapped = (r_state == IDLE) & w_req & ~w_hit;
    assign w_new_err  = w_unmapped | w_resp_err | w_timeout;

    // Select the cause code of the error event occurring this cycle
    always_comb begin
        w_new_cause = WB_ERR_NONE;
        if (w_unmapped) begin
            w_new_cause = WB_ERR_UNMAPPED;
        end else if (w_resp_err) begin
            w_new_cause = WB_ERR_SLAVE;
        end else if (w_timeout) begin
            w_new_cause = WB_ERR_TIMEOUT;
        end else begin
            w_new_cause = WB_ERR_NONE;
        end
    end

    // One-hot slave select derived from the registered state and index
    always_comb begin
        w_sel_vec = '0;
        if (w_active) begin
            w_sel_vec = NUM_SLAVES'(1'b1) << r_idx;
        end else begin
            w_sel_vec = '0;
        end
    end

    assign s_cyc_o = w_sel_vec;
    assign s_stb_o = w_sel_vec;

    // Read data is only passed through while the transfer is being acked
    always_comb begin
        m_dat_o = '0;
        if (w_resp_ack) begin
            m_dat_o = w_sel_dat;
        end else begin
            m_dat_o = '0;
        end
    end

    assign m_ack_o = w_resp_ack;
    assign m_err_o = (r_state == ERR) | w_resp_err;

    // Transfer FSM: decode in IDLE, wait for response or timeout in ACTIVE, one-cycle ERR
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_req) begin
                        if (w_hit) begin
                            r_state <= ACTIVE;
                            r_idx   <= w_idx;
                        end else begin
                            r_state <= ERR;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ACTIVE: begin
                    if (!m_cyc_i) begin
                        r_state <= IDLE;
                    end else if (w_sel_ack | w_sel_err) begin
                        r_state <= IDLE;
                    end else if (w_cnt_last) begin
                        r_state <= ERR;
                    end else begin
                        r_cnt <= r_cnt + CW'(1'b1);
                    end
                end
                ERR: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Sticky capture of the first error; a clear pulse overrides a simultaneous error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_valid <= 1'b0;
            r_err_adr   <= '0;
            r_err_cause <= WB_ERR_NONE;
        end else if (err_clr_i) begin
            r_err_valid <= 1'b0;
            r_err_adr   <= '0;
            r_err_cause <= WB_ERR_NONE;
        end else if (w_new_err && !r_err_valid) begin
            r_err_valid <= 1'b1;
            r_err_adr   <= m_adr_i;
            r_err_cause <= w_new_cause;
        end else begin
            r_err_valid <= r_err_valid;
        end
    end

    assign err_valid_o = r_err_valid;
    assign err_adr_o   = r_err_adr;
    assign err_cause_o = r_err_cause;

endmodule

// File: tb/tb_wb_nslave_decoder.sv
// Directed bench for wb_nslave_decoder: 4 slaves, TIMEOUT=8.
module tb_wb_nslave_decoder;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                   clk;
    logic                   reset_n;
    logic [AW-1:0]          m_adr_i;
    logic [DW-1:0]          m_dat_i;
    logic [DW/8-1:0]        m_sel_i;
    logic                   m_we_i;
    logic                   m_cyc_i;
    logic                   m_stb_i;
    logic [DW-1:0]          m_dat_o;
    logic                   m_ack_o;
    logic                   m_err_o;
    logic [AW-1:0]          s_adr_o;
    logic [DW-1:0]          s_dat_o;
    logic [DW/8-1:0]        s_sel_o;
    logic                   s_we_o;
    logic [NS-1:0]          s_cyc_o;
    logic [NS-1:0]          s_stb_o;
    logic [NS-1:0][DW-1:0]  s_dat_i;
    logic [NS-1:0]          s_ack_i;
    logic [NS-1:0]          s_err_i;
    logic                   err_valid_o;
    logic [AW-1:0]          err_adr_o;
    logic [1:0]             err_cause_o;
    logic                   err_clr_i;

    int n_tests = 0;
    int n_fail  = 0;

    wb_nslave_decoder #(
        .NUM_SLAVES (NS),
        .AW         (AW),
        .DW         (DW),
        .SLV_BASE   ({32'h8000_0000, 32'h8000_0000, 32'h2000_0000, 32'h0000_0000}),
        .SLV_MASK   ({32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT    (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m_adr_i     (m_adr_i),
        .m_dat_i     (m_dat_i),
        .m_sel_i     (m_sel_i),
        .m_we_i      (m_we_i),
        .m_cyc_i     (m_cyc_i),
        .m_stb_i     (m_stb_i),
        .m_dat_o     (m_dat_o),
        .m_ack_o     (m_ack_o),
        .m_err_o     (m_err_o),
        .s_adr_o     (s_adr_o),
        .s_dat_o     (s_dat_o),
        .s_sel_o     (s_sel_o),
        .s_we_o      (s_we_o),
        .s_cyc_o     (s_cyc_o),
        .s_stb_o     (s_stb_o),
        .s_dat_i     (s_dat_i),
        .s_ack_i     (s_ack_i),
        .s_err_i     (s_err_i),
        .err_valid_o (err_valid_o),
        .err_adr_o   (err_adr_o),
        .err_cause_o (err_cause_o),
        .err_clr_i   (err_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] adr, input logic we);
        m_adr_i = adr;
        m_we_i  = we;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
    endtask

    task automatic drop();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        m_we_i  = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        m_adr_i   = 32'h0;
        m_dat_i   = 32'h0;
        m_sel_i   = 4'h0;
        m_we_i    = 1'b0;
        m_cyc_i   = 1'b0;
        m_stb_i   = 1'b0;
        s_dat_i   = '0;
        s_ack_i   = 4'h0;
        s_err_i   = 4'h0;
        err_clr_i = 1'b0;

        // Reset values
        #12;
        chk("rst_cyc", s_cyc_o, 4'h0);
        chk("rst_stb", s_stb_o, 4'h0);
        chk("rst_ack", m_ack_o, 1'b0);
        chk("rst_err", m_err_o, 1'b0);
        chk("rst_dat", m_dat_o, 32'h0);
        chk("rst_evalid", err_valid_o, 1'b0);
        chk("rst_ecause", err_cause_o, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;

        // Read 0x2000_0010 from slave1, ack on second ACTIVE cycle
        @(negedge clk);
        req(32'h2000_0010, 1'b0);
        #1;
        chk("rd1_idle_stb", s_stb_o, 4'h0);
        chk("rd1_adr_bcast", s_adr_o, 32'h2000_0010);
        @(negedge clk); #1;
        chk("rd1_act1_stb", s_stb_o, 4'b0010);
        chk("rd1_act1_cyc", s_cyc_o, 4'b0010);
        chk("rd1_act1_ack", m_ack_o, 1'b0);
        @(negedge clk);
        s_ack_i    = 4'b0010;
        s_dat_i[1] = 32'hDEAD_BEEF;
        #1;
        chk("rd1_ack", m_ack_o, 1'b1);
        chk("rd1_dat", m_dat_o, 32'hDEAD_BEEF);
        chk("rd1_noerr", m_err_o, 1'b0);
        @(negedge clk);
        s_ack_i = 4'h0;
        drop();
        #1;
        chk("rd1_post_ack", m_ack_o, 1'b0);
        chk("rd1_post_dat", m_dat_o, 32'h0);
        chk("rd1_post_stb", s_stb_o, 4'h0);

        // Read 0x8000_0004: slaves 2 and 3 overlap, slave2 wins, slave3 ack ignored
        @(negedge clk);
        req(32'h8000_0004, 1'b0);
        @(negedge clk); #1;
        chk("ovl_stb", s_stb_o, 4'b0100);
        @(negedge clk);
        s_ack_i    = 4'b1000;
        s_dat_i[3] = 32'h3333_3333;
        #1;
        chk("ovl_s3_ignored", m_ack_o, 1'b0);
        chk("ovl_s3_dat", m_dat_o, 32'h0);
        @(negedge clk);
        s_ack_i    = 4'b0100;
        s_dat_i[2] = 32'h1234_5678;
        #1;
        chk("ovl_s2_ack", m_ack_o, 1'b1);
        chk("ovl_s2_dat", m_dat_o, 32'h1234_5678);
        @(negedge clk);
        s_ack_i = 4'h0;
        drop();

        // Write 0xF000_0000: unmapped
        @(negedge clk);
        req(32'hF000_0000, 1'b1);
        m_dat_i = 32'hA5A5_5A5A;
        m_sel_i = 4'b1010;
        #1;
        chk("um_we_bcast", s_we_o, 1'b1);
        chk("um_dat_bcast", s_dat_o, 32'hA5A5_5A5A);
        chk("um_sel_bcast", s_sel_o, 4'b1010);
        chk("um_req_noerr", m_err_o, 1'b0);
        @(negedge clk); #1;
        chk("um_err", m_err_o, 1'b1);
        chk("um_nostb", s_stb_o, 4'h0);
        chk("um_evalid", err_valid_o, 1'b1);
        chk("um_cause", err_cause_o, 2'b01);
        chk("um_adr", err_adr_o, 32'hF000_0000);
        drop();
        @(negedge clk); #1;
        chk("um_err_one_cycle", m_err_o, 1'b0);

        // Timeout on slave0 after clearing the capture
        clr_pulse();
        #1;
        chk("clr_valid", err_valid_o, 1'b0);
        chk("clr_cause", err_cause_o, 2'b00);
        chk("clr_adr", err_adr_o, 32'h0);
        @(negedge clk);
        req(32'h0000_0100, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk("to_act_stb", s_stb_o, 4'b0001);
            chk("to_act_noerr", m_err_o, 1'b0);
        end
        @(negedge clk); #1;
        chk("to_err", m_err_o, 1'b1);
        chk("to_stb_drop", s_stb_o, 4'h0);
        chk("to_cause", err_cause_o, 2'b11);
        chk("to_adr", err_adr_o, 32'h0000_0100);
        drop();

        // Second error keeps the first capture
        @(negedge clk);
        req(32'hF000_0004, 1'b1);
        @(negedge clk); #1;
        chk("e2_err", m_err_o, 1'b1);
        chk("e2_keep_cause", err_cause_o, 2'b11);
        chk("e2_keep_adr", err_adr_o, 32'h0000_0100);
        drop();

        // Error in the same cycle as clear: clear wins, not captured
        @(negedge clk);
        req(32'hF000_0008, 1'b0);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        #1;
        chk("e3_err", m_err_o, 1'b1);
        chk("e3_valid", err_valid_o, 1'b0);
        chk("e3_cause", err_cause_o, 2'b00);
        drop();

        // Slave1 ack and err together: err wins
        @(negedge clk);
        req(32'h2000_0000, 1'b0);
        @(negedge clk);
        s_ack_i    = 4'b0010;
        s_err_i    = 4'b0010;
        s_dat_i[1] = 32'hCAFE_F00D;
        #1;
        chk("ae_err", m_err_o, 1'b1);
        chk("ae_ack", m_ack_o, 1'b0);
        chk("ae_dat", m_dat_o, 32'h0);
        @(negedge clk);
        s_ack_i = 4'h0;
        s_err_i = 4'h0;
        drop();
        #1;
        chk("ae_err_gone", m_err_o, 1'b0);
        chk("ae_valid", err_valid_o, 1'b1);
        chk("ae_cause", err_cause_o, 2'b10);
        chk("ae_adr", err_adr_o, 32'h2000_0000);

        // Abort by dropping m_cyc_i three cycles into ACTIVE
        clr_pulse();
        @(negedge clk);
        req(32'h0000_0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("ab_act_stb", s_stb_o, 4'b0001);
        end
        @(negedge clk);
        drop();
        s_ack_i = 4'b0001;
        #1;
        chk("ab_noack", m_ack_o, 1'b0);
        chk("ab_noerr", m_err_o, 1'b0);
        @(negedge clk);
        s_ack_i = 4'h0;
        #1;
        chk("ab_cyc_off", s_cyc_o, 4'h0);
        chk("ab_nocapture", err_valid_o, 1'b0);

        // Asynchronous reset in the middle of ACTIVE
        @(negedge clk);
        req(32'h8000_0000, 1'b0);
        @(negedge clk); #1;
        chk("rs_act_cyc", s_cyc_o, 4'b0100);
        s_ack_i    = 4'b0100;
        s_dat_i[2] = 32'h0000_0055;
        #1;
        reset_n = 1'b0;
        #1;
        chk("rs_cyc_now", s_cyc_o, 4'h0);
        chk("rs_stb_now", s_stb_o, 4'h0);
        chk("rs_ack_now", m_ack_o, 1'b0);
        chk("rs_dat_now", m_dat_o, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        s_ack_i = 4'h0;
        drop();
        @(negedge clk); #1;
        chk("rs_idle_cyc", s_cyc_o, 4'h0);
        chk("rs_idle_ack", m_ack_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
